rc_pulse_validator: RTL
=======================

Name: rc_pulse_validator

Overview:
- Downstream consumer of one RC pulse-width decoder channel. Takes the decoder's ready strobe and 16-bit coded width word.
- Rejects error-flagged and out-of-range frames, requires consecutive good frames before lock, and enforces failsafe on signal loss or frame timeout.
- Publishes a zero-based throttle/stick value with an update strobe to the flight-control logic.

Parameters:
- clockFreq, 50000000, system clock Hz; microsecond tick divider = clockFreq/1_000_000.
- MIN_US, 1000, lowest accepted pulse width (us).
- MAX_US, 2000, highest accepted pulse width (us).
- LOCK_FRAMES, 4, consecutive good frames required to leave FAILSAFE (1..15).
- LOSS_FRAMES, 3, consecutive bad frames in LOCKED that force FAILSAFE (1..15).
- TIMEOUT_US, 50000, maximum us between frames before forced FAILSAFE (< 2^17).
- FAILSAFE_VALUE, 0, o_value while in FAILSAFE.

Ports:
- i_clk  in  1  system clock.
- i_resetn  in  1  reset, asynchronous, active-low.
- i_pwm_ready  in  1  decoder frame strobe; high 1+ cycles per frame.
- i_pwm_value  in  16  decoder word: [15:14]=11 off-time timeout; [15:14]=10 on-time overflow; [15]=0 width in us in [11:0].
- o_value  out  16  validated width minus MIN_US (0..MAX_US-MIN_US).
- o_update  out  1  one-cycle pulse when o_value is rewritten with a good sample.
- o_failsafe  out  1  high while in FAILSAFE.
- o_err_count  out  8  saturating count of bad frames.

Behaviour:
- Reset (async assert, sync release): o_value=FAILSAFE_VALUE, o_update=0, o_failsafe=1, o_err_count=0; state FAILSAFE; good/bad counters 0; timeout counter 0; us divider 0; edge register 0.
- Frame event: rising edge of i_pwm_ready, detected against its previous-cycle value. A strobe held high counts once. i_pwm_value is sampled in the edge cycle.
- Good frame: [15]=0 and MIN_US <= value <= MAX_US. Every other frame is bad; this includes [15]=0 with the width out of range.
- Bad frame: o_err_count increments, saturating at 255.
- FAILSAFE:
  - Good frame: good counter increments; on reaching LOCK_FRAMES, go to LOCKED and publish this sample.
  - Bad frame: good counter clears.
  - o_value holds FAILSAFE_VALUE; o_update stays 0.
- LOCKED:
  - Good frame: o_value <= value-MIN_US and o_update=1 the cycle after the edge (latency 1); bad counter clears.
  - Bad frame: o_value holds and the bad counter increments; on reaching LOSS_FRAMES, go to FAILSAFE.
- Entering FAILSAFE from any cause: o_value <= FAILSAFE_VALUE, o_failsafe <= 1, and good and bad counters clear, all in the same cycle.
- Entering LOCKED: o_failsafe <= 0 in the same cycle o_update pulses.
- Timeout:
  - us tick counter runs continuously.
  - Timeout counter increments per tick, saturates at TIMEOUT_US, and clears on every frame event.
  - In LOCKED, reaching TIMEOUT_US forces FAILSAFE.
  - In FAILSAFE, reaching TIMEOUT_US clears the good counter.
- Simultaneous frame event and timeout expiry: the frame event wins; the counter clears and the frame is processed normally.
- Reset mid-frame: all state is discarded; the next edge after release is the first frame.
- Arithmetic is unsigned 16-bit; the subtraction is performed only on good frames and never underflows.

Optional Feature:
- Macro: RC_PULSE_VALIDATOR_AVG_EN.
- Defined:
  - In LOCKED, o_value is the 4-sample moving average of good (value-MIN_US) samples: sum of last 4, 18-bit, shifted right by 2, truncated.
  - On entry to LOCKED, all 4 history slots are preloaded with the entering sample.
  - Bad frames do not enter history.
  - o_update latency is 2 cycles after the edge.
  - FAILSAFE and timeout behaviour are unchanged.
- Undefined: no history registers; o_value is the raw sample at latency 1.

Test Plan:
- Reset check: reset, then 4 strobes with value 1500 -> o_failsafe falls and o_update pulses on the 4th; o_value=500; strobes 1-3 give o_value=0, o_failsafe=1.
- LOCKED updates and held strobe: in LOCKED, strobe 1000, 2000, 0x07D1 (2001) -> o_value 0, 1000, then held at 1000 with no o_update; o_err_count=1. Holding i_pwm_ready high 5 cycles yields a single o_update.
- Loss by bad frames: in LOCKED, send 0x8A28, 0xC000, 0x8A28 -> FAILSAFE after the 3rd, o_value=0. With 0x8A28, 1500, 0x8A28, 0xC000 -> stays LOCKED, since good frames clear the bad count.
- Frame timeout: in LOCKED, no strobes for 50000 us (2.5M cycles at 50 MHz) -> o_failsafe=1 at expiry. A strobe landing exactly on the expiry cycle keeps LOCKED.
- Error counter and async reset: 300 bad frames -> o_err_count=255. Asserting i_resetn low asynchronously mid-strobe -> all outputs at reset values immediately.
- RC_PULSE_VALIDATOR_AVG_EN: lock at 1400, then good 1800, 1800, 1800 -> o_value 400, 500, 600, 700; o_update 2 cycles after each edge.

Source files
------------

// File: rtl/rc_pulse_validator_if.sv
// Frame bus from an RC pulse-width decoder channel to its validator.
// The decoder drives the master side; the validator listens on the slave side.
interface rc_pulse_validator_if;
    logic        pwm_ready;
    logic [15:0] pwm_value;

    modport master (output pwm_ready, output pwm_value);
    modport slave  (input  pwm_ready, input  pwm_value);
endinterface

// File: rtl/rc_pulse_validator.sv
// Validates decoded RC pulse widths: range/error filtering, lock/loss hysteresis, frame timeout failsafe.
// Define RC_PULSE_VALIDATOR_AVG_EN to publish a 4-sample moving average while locked.
module rc_pulse_validator #(
    parameter int clockFreq      = 50_000_000,
    parameter int MIN_US         = 1000,
    parameter int MAX_US         = 2000,
    parameter int LOCK_FRAMES    = 4,
    parameter int LOSS_FRAMES    = 3,
    parameter int TIMEOUT_US     = 50000,
    parameter int FAILSAFE_VALUE = 0
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    rc_pulse_validator_if.slave   pwm,
    output logic [15:0]           o_value,
    output logic                  o_update,
    output logic                  o_failsafe,
    output logic [7:0]            o_err_count
);

    localparam int TICK_DIV = (clockFreq / 1_000_000 < 1) ? 1 : clockFreq / 1_000_000;

    typedef enum logic {ST_FAILSAFE, ST_LOCKED} state_t;

    state_t      state;
    logic        prev_ready;
    logic [31:0] div_cnt;
    logic [16:0] to_cnt;
    logic [3:0]  good_cnt;
    logic [3:0]  bad_cnt;

    logic        tick;
    logic        frame_evt;
    logic        sample_good;
    logic        expire;
    logic        to_failsafe;
    logic [15:0] width;
    logic [15:0] sample;

`ifdef RC_PULSE_VALIDATOR_AVG_EN
    logic [15:0] hist0, hist1, hist2, hist3;
    logic        publish;
    logic [17:0] avg_sum;
`endif

    // Bits [14:12] are zero for any in-range width, so using [14:0] keeps out-of-range codes bad.
    always_comb begin
        width       = {1'b0, pwm.pwm_value[14:0]};
        sample_good = !pwm.pwm_value[15] && (width >= 16'(MIN_US)) && (width <= 16'(MAX_US));
        sample      = sample_good ? (width - 16'(MIN_US)) : 16'd0;
        tick        = (div_cnt == 32'(TICK_DIV - 1));
        frame_evt   = pwm.pwm_ready && !prev_ready;
        expire      = tick && (to_cnt == 17'(TIMEOUT_US - 1)) && !frame_evt;
        to_failsafe = (state == ST_LOCKED) &&
                      ((frame_evt && !sample_good && (bad_cnt == 4'(LOSS_FRAMES - 1))) || expire);
`ifdef RC_PULSE_VALIDATOR_AVG_EN
        avg_sum     = 18'(hist0) + 18'(hist1) + 18'(hist2) + 18'(hist3);
`endif
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            prev_ready <= 1'b0;
            div_cnt    <= '0;
            to_cnt     <= '0;
        end else begin
            prev_ready <= pwm.pwm_ready;
            div_cnt    <= tick ? 32'd0 : div_cnt + 32'd1;
            if (frame_evt)
                to_cnt <= '0;
            else if (tick && (to_cnt != 17'(TIMEOUT_US)))
                to_cnt <= to_cnt + 17'd1;
        end
    end

    // Failsafe entry is applied last so it overrides any publish scheduled in the same cycle.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state       <= ST_FAILSAFE;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            o_value     <= 16'(FAILSAFE_VALUE);
            o_update    <= 1'b0;
            o_failsafe  <= 1'b1;
            o_err_count <= '0;
`ifdef RC_PULSE_VALIDATOR_AVG_EN
            hist0       <= '0;
            hist1       <= '0;
            hist2       <= '0;
            hist3       <= '0;
            publish     <= 1'b0;
`endif
        end else begin
            o_update <= 1'b0;
`ifdef RC_PULSE_VALIDATOR_AVG_EN
            publish  <= 1'b0;
            if (publish) begin
                o_value    <= avg_sum[17:2];
                o_update   <= 1'b1;
                o_failsafe <= 1'b0;
            end
`endif
            if (frame_evt) begin
                if (!sample_good && (o_err_count != 8'hFF))
                    o_err_count <= o_err_count + 8'd1;
                case (state)
                    ST_FAILSAFE: begin
                        if (!sample_good) begin
                            good_cnt <= '0;
                        end else if (good_cnt == 4'(LOCK_FRAMES - 1)) begin
                            state    <= ST_LOCKED;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
`ifdef RC_PULSE_VALIDATOR_AVG_EN
                            hist0    <= sample;
                            hist1    <= sample;
                            hist2    <= sample;
                            hist3    <= sample;
                            publish  <= 1'b1;
`else
                            o_value    <= sample;
                            o_update   <= 1'b1;
                            o_failsafe <= 1'b0;
`endif
                        end else begin
                            good_cnt <= good_cnt + 4'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (sample_good) begin
                            bad_cnt <= '0;
`ifdef RC_PULSE_VALIDATOR_AVG_EN
                            hist0   <= sample;
                            hist1   <= hist0;
                            hist2   <= hist1;
                            hist3   <= hist2;
                            publish <= 1'b1;
`else
                            o_value  <= sample;
                            o_update <= 1'b1;
`endif
                        end else begin
                            bad_cnt <= bad_cnt + 4'd1;
                        end
                    end
                    default: state <= ST_FAILSAFE;
                endcase
            end else if (expire && (state == ST_FAILSAFE)) begin
                good_cnt <= '0;
            end

            if (to_failsafe) begin
                state      <= ST_FAILSAFE;
                o_value    <= 16'(FAILSAFE_VALUE);
                o_update   <= 1'b0;
                o_failsafe <= 1'b1;
                good_cnt   <= '0;
                bad_cnt    <= '0;
`ifdef RC_PULSE_VALIDATOR_AVG_EN
                publish    <= 1'b0;
`endif
            end
        end
    end

endmodule
